wrr_arbiter: RTL and testbench
==============================

WRR_ARBITER -- requirements
Module: wrr_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, payload width.
REQ-003 SHALL have parameter WEIGHT_WIDTH, default 4, per-requester burst-credit width.
REQ-004 SHALL have port aclk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port areset_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port req_valid_i, input, N_REQ, per-requester valid.
REQ-007 SHALL have port req_data_i, input, N_REQ*DATA_WIDTH, payloads; requester k in slice k.
REQ-008 SHALL have port req_ready_o, output, N_REQ, per-requester ready.
REQ-009 SHALL have port weight_i, input, N_REQ*WEIGHT_WIDTH, per-requester beats per grant.
REQ-010 SHALL have port out_valid_o, output, 1, registered output valid.
REQ-011 SHALL have port out_data_o, output, DATA_WIDTH, registered output payload.
REQ-012 SHALL have port out_ready_i, input, 1, downstream ready.
REQ-013 SHALL have port grant_id_o, output, $clog2(N_REQ), index of current owner; valid in GRANT.

Function
REQ-014 SHALL implement FSM IDLE/GRANT; transfer on any interface = valid & ready in the same cycle.
REQ-015 In IDLE with any req_valid_i set: pick first valid index scanning ptr, ptr+1, ... mod N_REQ; register grant_id_o; load credit = weight_i[g], weight 0 treated as 1; next state GRANT.
REQ-016 Arbitration latency: 1 cycle from IDLE request to GRANT; req_ready_o all-zero in IDLE.
REQ-017 In GRANT: req_ready_o[g] = !out_valid_o | out_ready_i; all other req_ready_o bits 0.
REQ-018 Accepted beat: out_data_o <= req_data_i[g], out_valid_o <= 1 next cycle; credit decrements by 1.
REQ-019 out_valid_o clears after an output transfer with no new accept; holds value and data while out_ready_i=0.
REQ-020 Grant release when the accepted beat brings credit to 0, or req_valid_i[g]=0 in GRANT; then ptr <= g+1 mod N_REQ and state IDLE.
REQ-021 Release to IDLE costs exactly one bubble cycle; queued output beat still drains during IDLE.
REQ-022 weight_i sampled only at grant load; changes mid-grant take effect at next grant.
REQ-023 Single requester continuously valid SHALL be re-granted after each bubble; no starvation: every valid requester granted within N_REQ grants.

Reset
REQ-024 areset_n low: state IDLE, ptr 0, credit 0, grant_id_o 0, out_valid_o 0, out_data_o 0, req_ready_o 0, immediately.
REQ-025 Reset mid-grant SHALL drop any buffered beat; after release first grant restarts from index 0.

Configuration
REQ-026 Macro WRR_STATS_EN defined: ports stats_clr_i (input 1) and stats_cnt_o (output N_REQ*16) exist; per-requester 16-bit saturating counter of accepted beats, synchronous clear on stats_clr_i, clear beats increment.
REQ-027 Macro WRR_STATS_EN undefined: those ports and counters absent; all other behaviour identical.

Structure
REQ-028 Package wrr_arbiter_pkg SHALL hold state enum (IDLE, GRANT) and default parameter constants.
REQ-029 Rotating priority search SHALL be sub-module rr_pick (combinational: valid vector, ptr -> index, found).

Verification
REQ-030 Only req 2 valid, weight 3, out_ready 1: three beats out, grant_id 2, bubble, re-grant to 2.
REQ-031 All 4 valid, weights 1,2,3,4, ready 1: output order 0,1,1,2,2,2,3,3,3,3, then repeats from 0.
REQ-032 Req 1 granted weight 4, out_ready_i 0 for 5 cycles after first beat: out_data_o stable, req_ready_o[1]=0, no credit change.
REQ-033 Req 0 drops valid after 1 of 4 beats: release, ptr=1, next grant to next valid index.
REQ-034 areset_n low during GRANT with out_valid_o=1: out_valid_o 0 same cycle; after release grant from index 0.
REQ-035 WRR_STATS_EN, 70000 beats from req 3: stats_cnt_o[3] saturates at 16'hFFFF; stats_clr_i zeroes all.

Source files
------------

// File: rtl/wrr_arbiter_pkg.sv
// rtl/wrr_arbiter_pkg.sv - shared state encoding and default parameters for wrr_arbiter
package wrr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } wrr_state_t;

   localparam int WRR_DEF_N_REQ        = 4;
   localparam int WRR_DEF_DATA_WIDTH   = 16;
   localparam int WRR_DEF_WEIGHT_WIDTH = 4;
   localparam int WRR_STATS_WIDTH      = 16;

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// rtl/wrr_arbiter_rr_pick.sv - rotating-priority search: first valid index at or after ptr
module rr_pick
   import wrr_arbiter_pkg::*;
#(
   parameter int N_REQ = WRR_DEF_N_REQ
)(
   input  logic [N_REQ-1:0]         valid_i,
   input  logic [$clog2(N_REQ)-1:0] ptr_i,
   output logic [$clog2(N_REQ)-1:0] idx_o,
   output logic                     found_o
);

   localparam int IW = $clog2(N_REQ);

   // Walk the requesters starting at ptr and wrapping; the first valid one wins.
   always_comb begin
      logic          hit;
      logic [IW-1:0] cand;
      hit   = 1'b0;
      cand  = '0;
      idx_o = '0;
      for (int off = 0; off < N_REQ; off++) begin
         cand = IW'((int'(ptr_i) + off) % N_REQ);
         if (!hit && valid_i[cand]) begin
            hit   = 1'b1;
            idx_o = cand;
         end
      end
      found_o = hit;
   end

endmodule

// File: rtl/wrr_arbiter.sv
// rtl/wrr_arbiter.sv - weighted round-robin arbiter with registered output stage (optional WRR_STATS_EN beat counters)
module wrr_arbiter
   import wrr_arbiter_pkg::*;
#(
   parameter int N_REQ        = WRR_DEF_N_REQ,
   parameter int DATA_WIDTH   = WRR_DEF_DATA_WIDTH,
   parameter int WEIGHT_WIDTH = WRR_DEF_WEIGHT_WIDTH
)(
   input  logic                            aclk,
   input  logic                            areset_n,
   input  logic [N_REQ-1:0]                req_valid_i,
   input  logic [N_REQ*DATA_WIDTH-1:0]     req_data_i,
   output logic [N_REQ-1:0]                req_ready_o,
   input  logic [N_REQ*WEIGHT_WIDTH-1:0]   weight_i,
   output logic                            out_valid_o,
   output logic [DATA_WIDTH-1:0]           out_data_o,
   output logic [$clog2(N_REQ)-1:0]        grant_id_o,
`ifdef WRR_STATS_EN
   input  logic                            stats_clr_i,
   output logic [N_REQ*WRR_STATS_WIDTH-1:0] stats_cnt_o,
`endif
   input  logic                            out_ready_i
);

   localparam int IW = $clog2(N_REQ);

   wrr_state_t              state_q, state_d;
   logic [IW-1:0]           ptr_q;
   logic [IW-1:0]           grant_q;
   logic [WEIGHT_WIDTH-1:0] credit_q;
   logic                    out_valid_q;
   logic [DATA_WIDTH-1:0]   out_data_q;

   logic [IW-1:0]           pick_idx;
   logic                    pick_found;
   logic                    grant_ready;
   logic                    accept;
   logic                    release_g;

   logic [WEIGHT_WIDTH-1:0] weight_arr [N_REQ];
   logic [DATA_WIDTH-1:0]   data_arr   [N_REQ];
   logic [WEIGHT_WIDTH-1:0] pick_weight;

   // Unpack the flat per-requester buses into indexable arrays.
   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         weight_arr[k] = weight_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
         data_arr[k]   = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
      .valid_i (req_valid_i),
      .ptr_i   (ptr_q),
      .idx_o   (pick_idx),
      .found_o (pick_found)
   );

   assign pick_weight = weight_arr[pick_idx];

   // State register.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) state_q <= IDLE;
      else           state_q <= state_d;
   end

   // Next state, owner handshake and release decision.
   always_comb begin
      state_d     = state_q;
      grant_ready = 1'b0;
      accept      = 1'b0;
      release_g   = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) state_d = GRANT;
         end
         GRANT: begin
            grant_ready = !out_valid_q || out_ready_i;
            accept      = req_valid_i[grant_q] && grant_ready;
            if (!req_valid_i[grant_q] || (accept && credit_q == WEIGHT_WIDTH'(1))) begin
               release_g = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Only the current owner sees ready, and only while the output slot can take a beat.
   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         req_ready_o[k] = grant_ready && (grant_q == IW'(k));
      end
   end

   // Grant bookkeeping: owner, burst credit and rotating pointer.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         grant_q  <= '0;
         credit_q <= '0;
         ptr_q    <= '0;
      end else begin
         if (state_q == IDLE && pick_found) begin
            grant_q  <= pick_idx;
            credit_q <= (pick_weight == '0) ? WEIGHT_WIDTH'(1) : pick_weight;
         end else if (accept) begin
            credit_q <= credit_q - WEIGHT_WIDTH'(1);
         end
         if (release_g) begin
            ptr_q <= (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + IW'(1);
         end
      end
   end

   // Single-entry output register: load on accept, empty after drain with no refill.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_data_q  <= data_arr[grant_q];
      end else if (out_ready_i) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign grant_id_o  = grant_q;

`ifdef WRR_STATS_EN
   logic [WRR_STATS_WIDTH-1:0] stats_q [N_REQ];

   // Per-requester saturating count of accepted beats; clear takes priority.
   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         for (int k = 0; k < N_REQ; k++) stats_q[k] <= '0;
      end else begin
         for (int k = 0; k < N_REQ; k++) begin
            if (stats_clr_i) begin
               stats_q[k] <= '0;
            end else if (accept && grant_q == IW'(k) && stats_q[k] != {WRR_STATS_WIDTH{1'b1}}) begin
               stats_q[k] <= stats_q[k] + WRR_STATS_WIDTH'(1);
            end
         end
      end
   end

   // Flatten counters onto the output bus.
   always_comb begin
      for (int k = 0; k < N_REQ; k++) begin
         stats_cnt_o[k*WRR_STATS_WIDTH +: WRR_STATS_WIDTH] = stats_q[k];
      end
   end
`endif

endmodule

// File: tb/tb_wrr_arbiter.sv
// tb/tb_wrr_arbiter.sv - randomized and directed checks of wrr_arbiter against a queue-based reference model
module tb_wrr_arbiter;

   localparam int N  = 4;
   localparam int DW = 16;
   localparam int WW = 4;
   localparam int IW = 2;

   logic              aclk = 1'b0;
   logic              areset_n;
   logic [N-1:0]      req_valid_i;
   logic [N*DW-1:0]   req_data_i;
   logic [N-1:0]      req_ready_o;
   logic [N*WW-1:0]   weight_i;
   logic              out_valid_o;
   logic [DW-1:0]     out_data_o;
   logic [IW-1:0]     grant_id_o;
   logic              out_ready_i;
`ifdef WRR_STATS_EN
   logic              stats_clr_i;
   logic [N*16-1:0]   stats_cnt_o;
`endif

   wrr_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW)) dut (
      .aclk        (aclk),
      .areset_n    (areset_n),
      .req_valid_i (req_valid_i),
      .req_data_i  (req_data_i),
      .req_ready_o (req_ready_o),
      .weight_i    (weight_i),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .grant_id_o  (grant_id_o),
`ifdef WRR_STATS_EN
      .stats_clr_i (stats_clr_i),
      .stats_cnt_o (stats_cnt_o),
`endif
      .out_ready_i (out_ready_i)
   );

   always #5 aclk = ~aclk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: owner (-1 = none), beats left, rotation pointer, one-deep output queue.
   int             m_owner = -1;
   int             m_left  = 0;
   int             m_ptr   = 0;
   logic [DW-1:0]  m_outq[$];
   int             m_stats[N];
   int             dut_log[$];
   logic [N*WW-1:0] next_weight = '0;
   logic           next_clr = 1'b0;

   function automatic logic [N-1:0] model_ready();
      logic [N-1:0] r = '0;
      if (m_owner >= 0 && (m_outq.size() == 0 || out_ready_i)) r[m_owner] = 1'b1;
      return r;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_left  = 0;
      m_ptr   = 0;
      m_outq.delete();
      for (int k = 0; k < N; k++) m_stats[k] = 0;
   endtask

   task automatic compare_outputs();
      check_eq("req_ready", 32'(req_ready_o), 32'(model_ready()));
      check_eq("out_valid", 32'(out_valid_o), 32'(m_outq.size() > 0));
      if (m_outq.size() > 0) check_eq("out_data", 32'(out_data_o), 32'(m_outq[0]));
      if (m_owner >= 0) check_eq("grant_id", 32'(grant_id_o), 32'(m_owner));
`ifdef WRR_STATS_EN
      for (int k = 0; k < N; k++)
         check_eq("stats_cnt", 32'(stats_cnt_o[k*16 +: 16]), 32'(m_stats[k]));
`endif
      if (out_valid_o && out_ready_i) dut_log.push_back(int'(out_data_o[15:12]));
   endtask

   task automatic model_step();
      logic [N-1:0] rdy;
      bit           acc;
      bit           found;
      int           w;
      rdy = model_ready();
      acc = (m_owner >= 0) && req_valid_i[m_owner] && rdy[m_owner];
      if (m_outq.size() > 0 && out_ready_i) void'(m_outq.pop_front());
      if (acc) begin
         m_outq.push_back(req_data_i[m_owner*DW +: DW]);
         m_left--;
      end
`ifdef WRR_STATS_EN
      if (stats_clr_i) begin
         for (int k = 0; k < N; k++) m_stats[k] = 0;
      end else if (acc && m_stats[m_owner] < 65535) begin
         m_stats[m_owner]++;
      end
`endif
      if (m_owner < 0) begin
         found = 0;
         for (int i = 0; i < N; i++) begin
            int c;
            c = (m_ptr + i) % N;
            if (!found && req_valid_i[c]) begin
               found   = 1;
               m_owner = c;
               w       = int'(weight_i[c*WW +: WW]);
               m_left  = (w == 0) ? 1 : w;
            end
         end
      end else if (!req_valid_i[m_owner] || m_left == 0) begin
         m_ptr   = (m_owner + 1) % N;
         m_owner = -1;
      end
   endtask

   task automatic run_cycle(input logic [N-1:0] v, input logic ordy);
      @(posedge aclk);
      #1;
      req_valid_i = v;
      out_ready_i = ordy;
      weight_i    = next_weight;
`ifdef WRR_STATS_EN
      stats_clr_i = next_clr;
`endif
      for (int k = 0; k < N; k++) req_data_i[k*DW +: DW] = {4'(k), 12'($urandom)};
      @(negedge aclk);
      compare_outputs();
      model_step();
   endtask

   task automatic apply_reset();
      #2;
      areset_n    = 1'b0;
      req_valid_i = '0;
      out_ready_i = 1'b0;
      #1;
      check_eq("rst_out_valid", 32'(out_valid_o), 32'd0);
      check_eq("rst_req_ready", 32'(req_ready_o), 32'd0);
      check_eq("rst_grant_id", 32'(grant_id_o), 32'd0);
      check_eq("rst_out_data", 32'(out_data_o), 32'd0);
      model_reset();
      @(negedge aclk);
      areset_n = 1'b1;
   endtask

   initial begin
      int exp_seq[11];
      logic [DW-1:0] held;
      exp_seq = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3, 0};
      areset_n    = 1'b0;
      req_valid_i = '0;
      req_data_i  = '0;
      weight_i    = '0;
      out_ready_i = 1'b0;
`ifdef WRR_STATS_EN
      stats_clr_i = 1'b0;
`endif
      model_reset();
      #12;
      apply_reset();

      // Lone requester 2 with weight 3: bursts of three with a bubble, re-granted.
      next_weight = {4'd0, 4'd3, 4'd0, 4'd0};
      for (int i = 0; i < 12; i++) run_cycle(4'b0100, 1'b1);
      check_eq("lone_req_gid", 32'(grant_id_o), 32'd2);

      // All valid with weights 1..4: fixed output order starting from requester 0.
      apply_reset();
      next_weight = {4'd4, 4'd3, 4'd2, 4'd1};
      dut_log.delete();
      for (int i = 0; i < 24; i++) run_cycle(4'b1111, 1'b1);
      check_eq("wrr_seq_len", 32'(dut_log.size() >= 11), 32'd1);
      for (int i = 0; i < 11; i++)
         if (i < dut_log.size()) check_eq("wrr_seq", 32'(dut_log[i]), 32'(exp_seq[i]));

      // Downstream stall after first beat of requester 1: output frozen, no ready.
      apply_reset();
      next_weight = {4'd0, 4'd0, 4'd4, 4'd0};
      run_cycle(4'b0010, 1'b1);
      run_cycle(4'b0010, 1'b1);
      run_cycle(4'b0010, 1'b0);
      held = out_data_o;
      for (int i = 0; i < 4; i++) begin
         run_cycle(4'b0010, 1'b0);
         check_eq("stall_data", 32'(out_data_o), 32'(held));
         check_eq("stall_ready1", 32'(req_ready_o[1]), 32'd0);
      end
      for (int i = 0; i < 8; i++) run_cycle(4'b0010, 1'b1);

      // Requester 0 drops after one beat: release, scan resumes from index 1.
      apply_reset();
      next_weight = {4'd4, 4'd4, 4'd4, 4'd4};
      run_cycle(4'b0001, 1'b1);
      run_cycle(4'b0001, 1'b1);
      run_cycle(4'b1100, 1'b1);
      run_cycle(4'b1100, 1'b1);
      run_cycle(4'b1100, 1'b1);
      check_eq("drop_next_gid", 32'(grant_id_o), 32'd2);

      // Reset while a beat is buffered: output cleared at once, restart from index 0.
      run_cycle(4'b1111, 1'b0);
      run_cycle(4'b1111, 1'b0);
      check_eq("pre_rst_valid", 32'(out_valid_o), 32'd1);
      apply_reset();
      run_cycle(4'b1111, 1'b1);
      run_cycle(4'b1111, 1'b1);
      check_eq("post_rst_gid", 32'(grant_id_o), 32'd0);

      // Randomized traffic, weights changing mid-grant.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) next_weight = N*WW'($urandom);
         next_clr = ($urandom_range(0, 199) == 0);
         run_cycle(N'($urandom), ($urandom_range(0, 9) < 7));
      end
      next_clr = 1'b0;

`ifdef WRR_STATS_EN
      // Saturation of requester 3's beat counter, then clear.
      next_weight = {4'd15, 4'd0, 4'd0, 4'd0};
      for (int i = 0; i < 75000; i++) run_cycle(4'b1000, 1'b1);
      check_eq("stats_sat", 32'(stats_cnt_o[63:48]), 32'hFFFF);
      next_clr = 1'b1;
      run_cycle(4'b1000, 1'b1);
      next_clr = 1'b0;
      run_cycle(4'b0000, 1'b1);
      check_eq("stats_clr", 32'(stats_cnt_o[63:48]), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
